// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - default widths for PC, instruction, branch-LUT index and cycle counter
//   - the halt encoding (all ones)
//   - the fetch FSM state type
//   - the per-program start address table, selected by ProgSel
//   - the branch-target table, indexed by BranchIdx
// The two tables are plain constants so the assembler flow can regenerate
// this file without touching any of the fetch logic.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W    = 10;
  localparam int INST_W    = 9;
  localparam int LUT_IDX_W = 3;
  localparam int CNT_W     = 16;

  localparam int NUM_PROGS   = 4;
  localparam int NUM_TARGETS = 2 ** LUT_IDX_W;

  // An all-ones instruction word stops the program.
  localparam logic [INST_W-1:0] HALT_INST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Entry address of each program image in the ROM.
  localparam logic [ADDR_W-1:0] PROG_START [NUM_PROGS] = '{
    10'h000, 10'h100, 10'h200, 10'h300
  };

  // Branch destinations, element 0 first.
  localparam logic [ADDR_W-1:0] BR_TARGET [NUM_TARGETS] = '{
    10'h000, 10'h010, 10'h020, 10'h080,
    10'h200, 10'h3FC, 10'h3F0, 10'h1F0
  };

  // Start address for a program select value.
  function automatic logic [ADDR_W-1:0] prog_start_addr(input logic [1:0] sel);
    return PROG_START[sel];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut
// Purely combinational lookup of a branch destination from the branch-target
// table in fetch_pkg. Kept as its own module so the table source can change
// without disturbing the fetch control.
// Ports:
//   branch_idx  in   L   index into the branch-target table
//   target      out  A   PC value to load when the branch is taken
// ---------------------------------------------------------------------------
module branch_lut
  import fetch_pkg::*;
#(
  parameter int A = ADDR_W,
  parameter int L = LUT_IDX_W
) (
  input  logic [L-1:0] branch_idx,
  output logic [A-1:0] target
);

  // Table entries are stored at the package address width; resize to the
  // PC width used by this instance.
  always_comb begin
    target = A'(BR_TARGET[branch_idx]);
  end

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Program counter and fetch control sitting directly in front of the
// instruction ROM. The registered PC drives the ROM address; the ROM answers
// combinationally on InstIn in the same cycle. Each RUN cycle the PC either
// holds (stall), stops (halt word), jumps (branch LUT) or steps by one.
// Ports:
//   Clk          in   1   clock, rising edge
//   Reset_n      in   1   asynchronous active-low reset
//   Start        in   1   begin a program (honoured in IDLE and HALTED only)
//   ProgSel      in   2   selects the program start address
//   InstIn       in   W   ROM word at the current InstAddress
//   Stall        in   1   downstream hold request
//   BranchTaken  in   1   decoder requests a branch this cycle
//   BranchIdx    in   L   branch-target table index
//   InstAddress  out  A   registered PC / ROM address
//   InstValid    out  1   InstIn is a live instruction (RUN state)
//   Done         out  1   program has halted
//   CycleCount   out  CW  RUN cycles since the last start, saturating
// ---------------------------------------------------------------------------
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int A  = ADDR_W,
  parameter int W  = INST_W,
  parameter int L  = LUT_IDX_W,
  parameter int CW = CNT_W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [1:0]    ProgSel,
  input  logic [W-1:0]  InstIn,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic [L-1:0]  BranchIdx,
  output logic [A-1:0]  InstAddress,
  output logic          InstValid,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic          done_q, done_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;

  logic [A-1:0]  branch_target;
  logic [A-1:0]  start_addr;
  logic [CW-1:0] cycle_count_inc;
  logic          is_halt;

  branch_lut #(
    .A (A),
    .L (L)
  ) u_branch_lut (
    .branch_idx (BranchIdx),
    .target     (branch_target)
  );

  // Start address for the selected program, resized to the PC width.
  always_comb begin
    start_addr = A'(prog_start_addr(ProgSel));
  end

  // Halt detection compares against the package encoding at this
  // instance's instruction width.
  always_comb begin
    is_halt = (InstIn == W'(HALT_INST));
  end

  // Counter holds at all ones instead of wrapping so very long programs
  // report "at least this many" rather than a small bogus value.
  always_comb begin
    if (cycle_count_q == {CW{1'b1}}) begin
      cycle_count_inc = cycle_count_q;
    end else begin
      cycle_count_inc = cycle_count_q + CW'(1);
    end
  end

  // Next-state, next-PC and counter decisions. In RUN the ordering is
  // stall, then halt, then branch, then sequential; a stalled cycle still
  // counts while the halting cycle does not. Start is only looked at when
  // no program is running.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    done_d        = done_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d       = RUN;
          pc_d          = start_addr;
          done_d        = 1'b0;
          cycle_count_d = '0;
        end
      end

      RUN: begin
        if (Stall) begin
          cycle_count_d = cycle_count_inc;
        end else if (is_halt) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else if (BranchTaken) begin
          pc_d          = branch_target;
          cycle_count_d = cycle_count_inc;
        end else begin
          // Natural A-bit wrap: the last ROM word is followed by word 0.
          pc_d          = pc_q + A'(1);
          cycle_count_d = cycle_count_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All fetch state in one register bank with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign InstAddress = pc_q;
  assign Done        = done_q;
  assign CycleCount  = cycle_count_q;

  // Decoded from state only, so the decoder never sees a glitch from inputs.
  assign InstValid   = (state_q == RUN);

endmodule
